// File: rtl/priority_dec_pkg.sv
// Shared types and one-hot decode constants for the priority decoder block.
package priority_dec_pkg;

  typedef logic [1:0] code_t;

  typedef struct packed {
    logic  enc_valid;
    code_t code;
  } entry_t;

  localparam logic [3:0] ONEHOT_Y3 = 4'b0001;
  localparam logic [3:0] ONEHOT_Y2 = 4'b0010;
  localparam logic [3:0] ONEHOT_Y1 = 4'b0100;
  localparam logic [3:0] ONEHOT_Y0 = 4'b1000;

  // An index with enc_valid low means "no request" and decodes to all zeros.
  function automatic logic [3:0] decode_entry(entry_t e);
    logic [3:0] d;
    d = 4'b0000;
    if (e.enc_valid) begin
      case (e.code)
        2'd3:    d = ONEHOT_Y3;
        2'd2:    d = ONEHOT_Y2;
        2'd1:    d = ONEHOT_Y1;
        default: d = ONEHOT_Y0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/priority_dec_if.sv
// Push/pop boundary between the decoder top (master) and its entry buffer (slave).
interface priority_dec_if
  import priority_dec_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  entry_t           wdata;
  entry_t           rdata;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;

  // push/pop are only raised when the buffer can honour them (not full / not empty).
  modport master (output push, pop, wdata, input rdata, full, empty, level);
  modport slave  (input push, pop, wdata, output rdata, full, empty, level);
endinterface

// File: rtl/priority_dec_fifo.sv
// Circular entry buffer with power-of-two depth; pointers wrap naturally.
module priority_dec_fifo
  import priority_dec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  priority_dec_if.slave  f
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (f.push) r_wptr <= r_wptr + 1'b1;
      if (f.pop)  r_rptr <= r_rptr + 1'b1;
      case ({f.push, f.pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by empty until written.
  always_ff @(posedge clk) begin
    if (f.push) r_mem[r_wptr] <= f.wdata;
  end

  assign f.rdata = r_mem[r_rptr];
  assign f.full  = (r_level == LVL_W'(DEPTH));
  assign f.empty = (r_level == '0);
  assign f.level = r_level;

endmodule

// File: rtl/priority_dec.sv
// Buffered one-hot reconstruction of encoded priority indices.
// Optional consumed-word counter enabled by defining PRIORITY_DEC_STATS_EN.
module priority_dec
  import priority_dec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             Y,
  input  logic                   enc_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             D,
  output logic                   D_valid,
  output logic [$clog2(DEPTH):0] level
`ifdef PRIORITY_DEC_STATS_EN
  ,
  output logic [7:0]             stat_count
`endif
);
  // Handshake: a word moves when valid and ready are both high on a rising edge.
  // in_ready depends on fullness only, so a pop never frees space in the same cycle.
  priority_dec_if #(.DEPTH(DEPTH)) u_fifo_if ();

  priority_dec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk (clk),
    .rst (rst),
    .f   (u_fifo_if.slave)
  );

  logic w_push;
  logic w_pop;

  assign in_ready        = !u_fifo_if.full;
  assign out_valid       = !u_fifo_if.empty;
  assign w_push          = in_valid && in_ready;
  assign w_pop           = out_ready && out_valid;
  assign u_fifo_if.push  = w_push;
  assign u_fifo_if.pop   = w_pop;
  assign u_fifo_if.wdata = '{enc_valid: enc_valid, code: Y};
  assign level           = u_fifo_if.level;

  // Decode only the stored head entry; outputs are forced low while empty.
  always_comb begin
    D       = 4'b0000;
    D_valid = 1'b0;
    if (out_valid) begin
      D       = decode_entry(u_fifo_if.rdata);
      D_valid = u_fifo_if.rdata.enc_valid;
    end
  end

`ifdef PRIORITY_DEC_STATS_EN
  logic [7:0] r_stat_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_count <= '0;
    end else if (w_pop && (r_stat_count != 8'hFF)) begin
      r_stat_count <= r_stat_count + 8'd1;
    end
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_priority_dec.sv
// Directed bench for priority_dec at DEPTH=4: vector table plus multi-cycle sequences.
module tb_priority_dec;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] Y;
  logic       enc_valid;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] D;
  logic       D_valid;
  logic [2:0] level;
`ifdef PRIORITY_DEC_STATS_EN
  logic [7:0] stat_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_q[$];

  priority_dec #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .enc_valid (enc_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .D_valid   (D_valid),
    .level     (level)
`ifdef PRIORITY_DEC_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] y;
    logic       ev;
    logic       ordy;
    logic       exp_ov;
    logic [3:0] exp_d;
    logic       exp_dv;
    logic [2:0] exp_lvl;
    logic       exp_ir;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic iv, logic [1:0] y, logic ev, logic ordy,
                              logic ov, logic [3:0] d, logic dv, logic [2:0] lvl, logic ir);
    vec_t v;
    v.iv = iv; v.y = y; v.ev = ev; v.ordy = ordy;
    v.exp_ov = ov; v.exp_d = d; v.exp_dv = dv; v.exp_lvl = lvl; v.exp_ir = ir;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, logic [1:0] y, logic ev, logic ordy);
    in_valid  = iv;
    Y         = y;
    enc_valid = ev;
    out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push_one(logic [1:0] y, logic ev, logic [3:0] d_exp);
    drive(1'b1, y, ev, 1'b0);
    cycle();
    exp_q.push_back(d_exp);
  endtask

  // Pops every expected word, checking the head before each pop, then checks empty.
  task automatic drain_check(string name);
    logic [3:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({name, "_ov"}, out_valid, 1'b1);
      chk({name, "_d"}, D, e);
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      cycle();
    end
    chk({name, "_empty"}, out_valid, 1'b0);
    chk({name, "_lvl0"}, level, 3'd0);
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #2;

    // Reset with in_valid high: no words accepted, outputs idle.
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    #1;
    chk("rst_ir", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    repeat (3) cycle();
    chk("rst_ir_hold", in_ready, 1'b1);
    chk("rst_ov_hold", out_valid, 1'b0);
    chk("rst_d", D, 4'b0000);
    chk("rst_dv", D_valid, 1'b0);
    chk("rst_lvl", level, 3'd0);
`ifdef PRIORITY_DEC_STATS_EN
    chk("rst_stat", stat_count, 8'd0);
`endif
    idle();
    rst_n = 1'b1;
    #1;

    //                iv    y     ev    ordy  ov    d        dv    lvl   ir
    vecs[0]  = mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 3'd1, 1'b1);
    vecs[1]  = mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 3'd1, 1'b1);
    vecs[2]  = mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 3'd1, 1'b1);
    vecs[3]  = mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 3'd1, 1'b1);
    vecs[4]  = mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b1);
    vecs[5]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd1, 1'b1);
    vecs[6]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    vecs[7]  = mk(1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
    vecs[8]  = mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 3'd1, 1'b1);
    vecs[9]  = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 3'd2, 1'b1);
    vecs[10] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, 3'd1, 1'b1);
    vecs[11] = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].y, vecs[i].ev, vecs[i].ordy);
      cycle();
      chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_d", i), D, vecs[i].exp_d);
      chk($sformatf("vec%0d_dv", i), D_valid, vecs[i].exp_dv);
      chk($sformatf("vec%0d_lvl", i), level, vecs[i].exp_lvl);
      chk($sformatf("vec%0d_ir", i), in_ready, vecs[i].exp_ir);
    end
    idle();

    // Fill to DEPTH with the consumer stalled; the fifth word must be dropped.
    push_one(2'd3, 1'b1, 4'b0001);
    push_one(2'd2, 1'b1, 4'b0010);
    push_one(2'd1, 1'b1, 4'b0100);
    push_one(2'd0, 1'b1, 4'b1000);
    chk("full_lvl", level, 3'd4);
    chk("full_ir", in_ready, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    cycle();
    chk("full_drop_lvl", level, 3'd4);
    chk("full_hold_d", D, 4'b0001);
    drain_check("full_drain");

    // Full with push and pop offered: only the pop happens; the push lands next cycle.
    push_one(2'd3, 1'b1, 4'b0001);
    push_one(2'd2, 1'b1, 4'b0010);
    push_one(2'd1, 1'b1, 4'b0100);
    push_one(2'd0, 1'b1, 4'b1000);
    void'(exp_q.pop_front());
    drive(1'b1, 2'd2, 1'b1, 1'b1);
    cycle();
    chk("nopass_lvl", level, 3'd3);
    chk("nopass_ir", in_ready, 1'b1);
    chk("nopass_d", D, 4'b0010);
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    cycle();
    exp_q.push_back(4'b0010);
    chk("refill_lvl", level, 3'd4);
    drain_check("refill_drain");

    // Asynchronous reset mid-operation at level 3 discards everything at once.
    push_one(2'd3, 1'b1, 4'b0001);
    push_one(2'd2, 1'b1, 4'b0010);
    push_one(2'd1, 1'b1, 4'b0100);
    exp_q.delete();
    chk("prerst_lvl", level, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_lvl", level, 3'd0);
    chk("async_ov", out_valid, 1'b0);
    chk("async_ir", in_ready, 1'b1);
    chk("async_d", D, 4'b0000);
    cycle();
    rst_n = 1'b1;
    push_one(2'd0, 1'b1, 4'b1000);
    chk("postrst_lvl", level, 3'd1);
    drain_check("postrst_drain");

`ifdef PRIORITY_DEC_STATS_EN
    do_reset();
    chk("stat_clr", stat_count, 8'd0);
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 10; i++) cycle();
    chk("stat_10", stat_count, 8'd10);
    for (int i = 0; i < 290; i++) cycle();
    chk("stat_sat", stat_count, 8'd255);
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_dec.md
PRIORITY_DEC -- requirements
Module: priority_dec

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  code word offered.
REQ-005 SHALL have port in_ready  output  1  buffer can accept a word.
REQ-006 SHALL have port Y  input  2  encoded priority index.
REQ-007 SHALL have port enc_valid  input  1  encoder valid flag; 0 means no request asserted.
REQ-008 SHALL have port out_valid  output  1  decoded word available.
REQ-009 SHALL have port out_ready  input  1  consumer takes word.
REQ-010 SHALL have port D  output  4  reconstructed one-hot request vector.
REQ-011 SHALL have port D_valid  output  1  copy of stored enc_valid for head word.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-013 SHALL accept a word on a cycle where in_valid and in_ready are both 1; in_ready = (level != DEPTH).
REQ-014 SHALL store {enc_valid, Y} per entry in arrival order (FIFO).
REQ-015 SHALL drive out_valid = (level != 0); the word is consumed on a cycle where out_valid and out_ready are both 1.
REQ-016 SHALL decode the head entry: enc_valid=0 -> D=0000; else Y=3 -> 0001, Y=2 -> 0010, Y=1 -> 0100, Y=0 -> 1000.
REQ-017 SHALL decode from registered head storage only; no combinational path from Y/enc_valid to D.
REQ-018 SHALL have latency exactly 1 cycle: a word accepted at edge N is visible on D/out_valid after edge N when the buffer was empty.
REQ-019 SHALL NOT pass through: when full, in_ready=0 even if out_ready=1 in the same cycle.
REQ-020 SHALL, on simultaneous push and pop when neither full nor empty, keep level unchanged and perform both.
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL hold D, D_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive D=0000 and D_valid=0 whenever out_valid=0.
REQ-024 SHALL ignore in_valid when in_ready=0 and ignore out_ready when out_valid=0.

Reset
REQ-025 SHALL, on rst low, immediately clear pointers and level; outputs: in_ready=1, out_valid=0, D=0000, D_valid=0, level=0.
REQ-026 SHALL discard all buffered words on reset asserted mid-operation; no word accepted before reset appears after it.
REQ-027 SHALL resume accepting on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with PRIORITY_DEC_STATS_EN defined, add output stat_count (8 bits): count of words consumed, saturating at 255, cleared by reset.
REQ-029 SHALL, without PRIORITY_DEC_STATS_EN, omit stat_count port and logic entirely; all other behaviour identical.

Structure
REQ-030 SHALL place typedef code_t (2-bit index), typedef entry_t ({enc_valid, code_t}) and the four one-hot decode constants in package priority_dec_pkg.
REQ-031 SHALL implement buffering in sub-module priority_dec_fifo (DEPTH parameter, push/pop/full/empty/level); top holds decode and stats.

Verification
REQ-032 SHALL cover: rst low with in_valid=1 -> in_ready=1, out_valid=0, D=0000, level=0.
REQ-033 SHALL cover: push Y=3,2,1,0 (enc_valid=1), out_ready=1 -> D=0001,0010,0100,1000 in order, first one cycle after accept.
REQ-034 SHALL cover: push enc_valid=0, Y=2 -> D=0000, D_valid=0, out_valid=1.
REQ-035 SHALL cover: out_ready=0, push 5 words at DEPTH=4 -> level=4, in_ready=0, 5th dropped; then drain yields first 4 only.
REQ-036 SHALL cover: full buffer with in_valid=1, out_ready=1 -> one pop, no push that cycle; next cycle push accepted, level stays 4.
REQ-037 SHALL cover: rst pulse with level=3 -> level=0 immediately; with PRIORITY_DEC_STATS_EN, 300 pops -> stat_count=255.
